// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the N-to-1 pipelined select stage: default widths,
// error encoding and a constant-foldable clog2 helper.
package mux_pkg;

  localparam int NB_DATA_DEF  = 32;
  localparam int N_INPUTS_DEF = 4;

  localparam logic SEL_ERR = 1'b1;

  // Never returns less than 1 so a select port always has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Upstream/downstream handshake bundle for mux_n_pipe; slave is the block's
// view, master is the view of whoever drives it.
interface mux_n_pipe_if
  import mux_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int N_INPUTS = N_INPUTS_DEF
);

  localparam int NB_SEL = clog2(N_INPUTS);

  logic [N_INPUTS*NB_DATA-1:0] i_data;
  logic [NB_SEL-1:0]           i_sel;
  logic                        i_valid;
  logic                        o_ready;
  logic                        i_flush;
  logic [NB_DATA-1:0]          o_data;
  logic                        o_sel_err;
  logic                        o_valid;
  logic                        i_ready;

  modport slave (
    input  i_data, i_sel, i_valid, i_flush, i_ready,
    output o_ready, o_data, o_sel_err, o_valid
  );

  modport master (
    output i_data, i_sel, i_valid, i_flush, i_ready,
    input  o_ready, o_data, o_sel_err, o_valid
  );

endinterface

// File: rtl/mux_n_pipe_skid_reg.sv
// Generic 2-entry valid/ready register: a visible main entry plus a hidden
// skid entry, so o_ready is a flop and never depends on i_ready.
module skid_reg #(
  parameter int NB = 33
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [NB-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_flush,
  output logic [NB-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready
);

  logic [NB-1:0] main_data_q, main_data_d;
  logic          main_valid_q, main_valid_d;
  logic [NB-1:0] skid_data_q, skid_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic          consume;
  logic          accept;

  // Data registers only load on a real transfer, so idle cycles cause no toggling.
  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    consume      = main_valid_q & i_ready;
    accept       = i_valid & ~skid_valid_q;

    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      if (accept) begin
        main_data_d  = i_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = i_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign o_data  = main_data_q;
  assign o_valid = main_valid_q;
  assign o_ready = ~skid_valid_q;

endmodule

// File: rtl/mux_n_pipe.sv
// N-to-1 channel select followed by a registered, skid-buffered handshake
// stage; out-of-range selects yield zero data with o_sel_err set.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int N_INPUTS = N_INPUTS_DEF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mux_n_pipe_if.slave  bus
);

  localparam int NB_SEL = clog2(N_INPUTS);

  logic [NB_DATA-1:0] sel_data;
  logic               sel_err;
  logic [NB_DATA:0]   stage_out;

  // Any select value with no matching channel falls through to the error default.
  always_comb begin
    sel_data = '0;
    sel_err  = SEL_ERR;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (bus.i_sel == NB_SEL'(k)) begin
        sel_data = bus.i_data[k*NB_DATA +: NB_DATA];
        sel_err  = ~SEL_ERR;
      end
    end
  end

  skid_reg #(
    .NB(NB_DATA + 1)
  ) u_skid_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  ({sel_err, sel_data}),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_flush (bus.i_flush),
    .o_data  (stage_out),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready)
  );

  assign bus.o_data    = stage_out[NB_DATA-1:0];
  assign bus.o_sel_err = stage_out[NB_DATA];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench: drives a 4-input and a 3-input instance with identical
// handshakes and checks both against a queue-based reference model.
module tb_mux_n_pipe;
  import mux_pkg::*;

  localparam int NB = 32;

  typedef struct {
    logic [NB-1:0] data;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.NB_DATA(NB), .N_INPUTS(4)) bus4 ();
  mux_n_pipe_if #(.NB_DATA(NB), .N_INPUTS(3)) bus3 ();

  mux_n_pipe #(.NB_DATA(NB), .N_INPUTS(4)) dut4 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus4)
  );

  mux_n_pipe #(.NB_DATA(NB), .N_INPUTS(3)) dut3 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus3)
  );

  logic [NB-1:0] chan [4];
  exp_t          sb [2][$];
  int            occ;
  int            vectors;
  int            miscompares;

  // Reference: a channel index picks that channel if it exists, otherwise zero with error.
  function automatic exp_t refModel(input int n, input int sel);
    exp_t e;
    if (sel < n) begin
      e.data = chan[sel];
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  task automatic checkBit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    checkBit("o_ready dut4", bus4.o_ready, occ < 2);
    checkBit("o_valid dut4", bus4.o_valid, occ > 0);
    checkBit("o_ready dut3", bus3.o_ready, occ < 2);
    checkBit("o_valid dut3", bus3.o_valid, occ > 0);
  endtask

  task automatic checkResetState();
    vectors += 2;
    if (bus4.o_data !== '0 || bus4.o_sel_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset dut4: got data=%h err=%b, expected 0/0", bus4.o_data, bus4.o_sel_err);
    end
    if (bus3.o_data !== '0 || bus3.o_sel_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset dut3: got data=%h err=%b, expected 0/0", bus3.o_data, bus3.o_sel_err);
    end
  endtask

  // Drives one cycle of inputs, advances the occupancy model, then checks the handshake.
  task automatic applyStimulus(input logic valid, input int sel, input logic ready,
                               input logic flush, input logic rst);
    logic ready_m, accept, consume;
    logic [1:0] sel_bits;
    sel_bits     = sel[1:0];
    reset        = rst;
    bus4.i_data  = {chan[3], chan[2], chan[1], chan[0]};
    bus3.i_data  = {chan[2], chan[1], chan[0]};
    bus4.i_sel   = sel_bits;
    bus3.i_sel   = sel_bits;
    bus4.i_valid = valid;
    bus3.i_valid = valid;
    bus4.i_ready = ready;
    bus3.i_ready = ready;
    bus4.i_flush = flush;
    bus3.i_flush = flush;
    ready_m = (occ < 2);
    accept  = valid && ready_m && !flush && !rst;
    consume = (occ > 0) && ready;
    if (accept) begin
      sb[0].push_back(refModel(4, sel));
      sb[1].push_back(refModel(3, sel));
    end
    if (rst || flush) occ = 0;
    else occ = occ + int'(accept) - int'(consume);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Monitor: whenever an output is presented it must match the oldest outstanding transfer.
  always @(negedge clk) begin
    logic          ov [2];
    logic [NB-1:0] od [2];
    logic          oe [2];
    ov[0] = bus4.o_valid; od[0] = bus4.o_data; oe[0] = bus4.o_sel_err;
    ov[1] = bus3.o_valid; od[1] = bus3.o_data; oe[1] = bus3.o_sel_err;
    if (reset) begin
      sb[0].delete();
      sb[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          vectors++;
          if (sb[d].size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected output dut%0d: got data=%h err=%b, expected no transfer",
                     d == 0 ? 4 : 3, od[d], oe[d]);
          end else begin
            if (od[d] !== sb[d][0].data || oe[d] !== sb[d][0].err) begin
              miscompares++;
              $display("[TB] FAIL data dut%0d: got data=%h err=%b, expected data=%h err=%b at %0t",
                       d == 0 ? 4 : 3, od[d], oe[d], sb[d][0].data, sb[d][0].err, $time);
            end
            if (bus4.i_ready) void'(sb[d].pop_front());
          end
        end
        if (bus4.i_flush) sb[d].delete();
      end
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    occ          = 0;
    reset        = 1'b1;
    bus4.i_data  = '0;
    bus3.i_data  = '0;
    bus4.i_sel   = '0;
    bus3.i_sel   = '0;
    bus4.i_valid = 1'b0;
    bus3.i_valid = 1'b0;
    bus4.i_ready = 1'b0;
    bus3.i_ready = 1'b0;
    bus4.i_flush = 1'b0;
    bus3.i_flush = 1'b0;
    for (int i = 0; i < 4; i++) chan[i] = '0;
    @(posedge clk);
    #1;

    $display("[TB] reset");
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkResetState();

    $display("[TB] basic select");
    for (int i = 0; i < 4; i++) chan[i] = NB'(i + 1);
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, s, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] out-of-range select");
    chan[0] = 32'hA; chan[1] = 32'hB; chan[2] = 32'hC; chan[3] = 32'hD;
    applyStimulus(1'b1, 3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) chan[i] = NB'(i + 1);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b1);
    checkResetState();
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random soak");
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) chan[i] = $urandom;
      applyStimulus($urandom_range(0, 9) < 7,
                    int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 6,
                    $urandom_range(0, 99) < 2,
                    $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checkBit("drained dut4", sb[0].size() == 0, 1'b1);
    checkBit("drained dut3", sb[1].size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
